// File: rtl/cnt_ioreg_n.sv
// cnt_ioreg_n: modulo-MODULUS up/down counter with an input register sharing one tri-state io bus.
// Single clock domain; clr clears counter and register asynchronously. tPD/tOE are model attributes only.
module cnt_ioreg_n #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 256,
    parameter int tPD     = 0,
    parameter int tOE     = 0
) (
    input  logic             clk,
    input  logic             clr,
    inout  logic [WIDTH-1:0] io,
    input  logic             rld,
    input  logic             cload_,
    input  logic             sclr_,
    input  logic             cen_,
    input  logic             ci_,
    input  logic             up,
    input  logic             g,
    input  logic             g_,
    output logic             tc,
    output logic             rco_
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH) || tPD < 0 || tOE < 0) begin : g_param_check
        $error("cnt_ioreg_n: invalid parameters WIDTH=%0d MODULUS=%0d tPD=%0d tOE=%0d",
               WIDTH, MODULUS, tPD, tOE);
    end

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] lreg;
    logic             oe;

    // Any unknown control at an edge poisons the count until the next clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if ($isunknown({sclr_, cload_, cen_, ci_, up})) begin
            cnt <= 'x;
        end else if (!sclr_) begin
            cnt <= '0;
        end else if (!cload_) begin
            cnt <= lreg;
        end else if (!cen_ && !ci_) begin
            if (up) begin
                cnt <= (cnt >= MAXV) ? '0 : cnt + 1'b1;
            end else begin
                cnt <= (cnt == '0) ? MAXV : cnt - 1'b1;
            end
        end
    end

    // Samples the resolved bus, so with the output enabled this snapshots cnt.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            lreg <= '0;
        end else if (rld) begin
            lreg <= io;
        end
    end

    assign oe   = g & ~g_;
    assign io   = oe ? cnt : 'z;
    assign tc   = up ? (cnt == MAXV) : (cnt == '0);
    assign rco_ = ~(tc & ~cen_ & ~ci_);

endmodule

// File: doc/cnt_ioreg_n.md
Name: cnt_ioreg_n

Overview:
Parametrised synchronous up/down counter with input register and shared tri-state I/O bus. This is the next-generation counter-with-input-register part for the TTL model library. Adds the following features:
- generic width and modulus
- count direction
- synchronous clear
- cascade enable
- terminal-count output

Everything runs on one clock, so the counter and the input register share a single timing domain. Intended for multi-chip cascaded counters and for bus-loaded address/sequence generators in board-level simulations.

Parameters:
WIDTH, 8, bit width of counter, input register and io bus
MODULUS, 256, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH
tPD, 0, clk/comb -> rco_/tc delay (ns), applied to rise and fall
tOE, 0, g/g_ -> io enable/disable delay (ns)

Ports:
clk  input  1  clock; all state changes on rising edge
clr  input  1  reset, asynchronous, active-high; clears counter and register
io  inout  WIDTH  bidirectional bus: register input, counter output
rld  input  1  register load enable, active-high; lreg <= io on clk rise
cload_  input  1  synchronous counter load from lreg, active-low
sclr_  input  1  synchronous counter clear, active-low
cen_  input  1  count enable, active-low
ci_  input  1  cascade carry-in enable, active-low
up  input  1  direction: 1 = up, 0 = down
g  input  1  output enable, active-high
g_  input  1  output enable, active-low
tc  output  1  terminal count, active-high
rco_  output  1  ripple carry out, active-low

Behaviour:
- Reset: clr=1 forces cnt=0 and lreg=0 immediately, independent of clk. While clr=1, clk edges have no effect on cnt or lreg. Outputs during reset: tc=0 if up=1, tc=1 if up=0; rco_=1 unless cen_=0, ci_=0 and tc=1.
- Counter update on clk rise when clr=0, strict priority:
  1. sclr_=0: cnt <= 0
  2. else cload_=0: cnt <= lreg, using the value held before this edge
  3. else cen_=0 and ci_=0: count
  4. else hold
- Count up: if cnt >= MODULUS-1 then cnt <= 0, else cnt <= cnt+1.
- Count down: if cnt == 0 then cnt <= MODULUS-1, else cnt <= cnt-1.
- Loaded values >= MODULUS are accepted unchanged. Up-count from such a value wraps to 0. Down-count decrements normally.
- Register: on clk rise with clr=0 and rld=1, lreg <= io (resolved bus value). rld acts independently of counter priority.
- rld and cload_ on the same edge: counter receives the old lreg; lreg takes the new io value. Latency io -> cnt via register is 2 edges.
- io is driven with cnt when g=1 and g_=0, after tOE; otherwise high-Z.
- rld=1 while io is driven: lreg captures the driven cnt value (bus loopback, counter snapshot).
- tc is combinational: 1 when (up=1 and cnt==MODULUS-1) or (up=0 and cnt==0). With MODULUS < 2**WIDTH, out-of-range values give tc=0.
- rco_ = ~(tc & ~cen_ & ~ci_), combinational, delayed by tPD. This allows synchronous cascading: stage n+1 ci_ connects to stage n rco_.
- X/Z on a control input at a clk edge: cnt becomes all-X. No other recovery; clr clears it.
- Initial state before the first clr: cnt and lreg are all-X.

Test Plan:
1. Reset mid-count: WIDTH=8, up=1, count to 0x37, assert clr between edges -> cnt=0x00 immediately; clk edges ignored while clr=1; after release, 3 edges -> io reads 0x03 (g=1, g_=0).
2. Up wrap, MODULUS=10: count from 0 -> sequence 0..9,0. tc=1 and rco_=0 only at 9 with cen_=ci_=0. ci_=1 at 9 -> rco_=1 and cnt holds 9.
3. Down wrap, MODULUS=10: cnt=0, up=0 -> tc=1; one edge -> cnt=9, tc=0.
4. Register load then count load: g=0, bus drives 0xA5, rld=1 on edge 1, cload_=0 on edge 2 -> cnt=0xA5 after edge 2. Repeat with rld and cload_ on the same edge, bus=0x3C, prior lreg=0xA5 -> cnt=0xA5, lreg=0x3C.
5. Priority: sclr_=0, cload_=0, cen_=0 on the same edge with cnt=0x10 -> cnt=0x00. Loopback: g=1, g_=0, cnt=0x42, rld=1 -> lreg=0x42.
6. Cascade: two WIDTH=4 instances, second ci_ tied to first rco_, up=1, 0x00 for 20 edges -> combined value 0x14; second stage increments only on the edge after the first shows 0xF.
